// File: rtl/csel_sub_pkg.sv
// ============================================================================
// Module  : csel_sub_pkg
// Brief   : Shared slice width and FSM state type for the carry-select subtractor
// Revision: 1.0
// ============================================================================
`default_nettype none

package csel_sub_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/csel_sub_slice.sv
// ============================================================================
// Module  : csel_sub_slice
// Brief   : Combinational 4-bit carry-select slice computing a + ~b + cin
// Revision: 1.0
// ============================================================================
`default_nettype none

module csel_sub_slice
  import csel_sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] sum_c0;
  logic [SLICE_W:0] sum_c1;

  // Both carry hypotheses are formed independently; the late-arriving cin only drives the mux.
  assign sum_c0 = {1'b0, a} + {1'b0, ~b};
  assign sum_c1 = {1'b0, a} + {1'b0, ~b} + {{SLICE_W{1'b0}}, 1'b1};

  always_comb begin
    s    = sum_c0[SLICE_W-1:0];
    cout = sum_c0[SLICE_W];
    if (cin) begin
      s    = sum_c1[SLICE_W-1:0];
      cout = sum_c1[SLICE_W];
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_csel_subtractor.sv
// ============================================================================
// Module  : seq_csel_subtractor
// Brief   : Sequential A - B - bin, one 4-bit carry-select slice per cycle.
//           Optional macro CSEL_SUB_SAT_EN saturates D on signed overflow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_csel_subtractor
  import csel_sub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;
  logic               a_msb;
  logic               b_msb;

  assign slice_a = a_q[int'(k_q)*SLICE_W +: SLICE_W];
  assign slice_b = b_q[int'(k_q)*SLICE_W +: SLICE_W];
  assign a_msb   = a_q[WIDTH-1];
  assign b_msb   = b_q[WIDTH-1];

  csel_sub_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          a_d     = A;
          b_d     = B;
          // Subtraction as A + ~B + 1, with the borrow-in folded into that +1.
          carry_d = ~bin;
          k_d     = '0;
          d_d     = '0;
          bout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end

      BUSY: begin
        d_d[int'(k_q)*SLICE_W +: SLICE_W] = slice_s;
        carry_d = slice_cout;
        k_d     = k_q + KW'(1);
        if (k_q == KW'(NSLICE - 1)) begin
          state_d = DONE;
          k_d     = '0;
          bout_d  = ~slice_cout;
          ovf_d   = (a_msb ^ b_msb) & (slice_s[SLICE_W-1] ^ a_msb);
`ifdef CSEL_SUB_SAT_EN
          if ((a_msb ^ b_msb) & (slice_s[SLICE_W-1] ^ a_msb)) begin
            d_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign D         = d_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_csel_subtractor.sv
// ============================================================================
// Module  : tb_seq_csel_subtractor
// Brief   : Self-checking bench for seq_csel_subtractor (WIDTH=32)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_csel_subtractor;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             bout;
  logic             ovf;

  int errors = 0;
  int checks = 0;

  seq_csel_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: exact integer subtraction; returns {ovf, bout, D}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic bi);
    logic [32:0] diff;
    longint      sd;
    logic        ov;
    logic [31:0] d;
    diff = {1'b0, a} - {1'b0, b} - {32'd0, bi};
    sd   = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
    ov   = (sd > 64'sh7FFFFFFF) || (sd < -64'sh80000000);
    d    = diff[31:0];
`ifdef CSEL_SUB_SAT_EN
    if (ov) d = (sd < 0) ? 32'h80000000 : 32'h7FFFFFFF;
`endif
    return {ov, diff[32], d};
  endfunction

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bi, output bit ok);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    ok = in_ready;
    A = a; B = b; bin = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Scrambles operands and in_valid while busy; they must have no effect.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      A = $urandom; B = $urandom; bin = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (out_valid) begin
        cyc = i;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic consume();
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (D !== 32'h0) begin errors++; $display("FAIL reset_D: got %h want 00000000", D); end
    checks++; if ({bout, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got bout=%b ovf=%b want 0 0", bout, ovf); end
  endtask

  task automatic test_directed();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic        vbi[4];
    logic [33:0] vexp[4];
    bit ok;
    int cyc;
    va[0] = 32'h00000005; vb[0] = 32'h00000003; vbi[0] = 1'b0; vexp[0] = {1'b0, 1'b0, 32'h00000002};
    va[1] = 32'h00000000; vb[1] = 32'h00000001; vbi[1] = 1'b0; vexp[1] = {1'b0, 1'b1, 32'hFFFFFFFF};
`ifdef CSEL_SUB_SAT_EN
    va[2] = 32'h80000000; vb[2] = 32'h00000001; vbi[2] = 1'b0; vexp[2] = {1'b1, 1'b0, 32'h80000000};
`else
    va[2] = 32'h80000000; vb[2] = 32'h00000001; vbi[2] = 1'b0; vexp[2] = {1'b1, 1'b0, 32'h7FFFFFFF};
`endif
    va[3] = 32'h00000010; vb[3] = 32'h0000000F; vbi[3] = 1'b1; vexp[3] = {1'b0, 1'b0, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      send(va[i], vb[i], vbi[i], ok);
      checks++; if (!ok) begin errors++; $display("FAIL dir%0d_accept: in_ready never rose", i); end
      wait_done(cyc);
      checks++; if (cyc != 8) begin errors++; $display("FAIL dir%0d_latency: got %0d want 8", i, cyc); end
      checks++; if ({ovf, bout, D} !== vexp[i]) begin
        errors++; $display("FAIL dir%0d_result: got ovf=%b bout=%b D=%h want ovf=%b bout=%b D=%h",
                           i, ovf, bout, D, vexp[i][33], vexp[i][32], vexp[i][31:0]);
      end
      consume();
      checks++; if ({in_ready, out_valid} !== 2'b10) begin
        errors++; $display("FAIL dir%0d_release: got in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] corner[4];
    logic [31:0] a, b;
    logic        bi;
    logic [33:0] exp_r;
    bit ok;
    int cyc;
    corner[0] = 32'h00000000; corner[1] = 32'hFFFFFFFF;
    corner[2] = 32'h80000000; corner[3] = 32'h7FFFFFFF;
    for (int i = 0; i < 40; i++) begin
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      bi = 1'($urandom_range(0, 1));
      exp_r = model(a, b, bi);
      send(a, b, bi, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_accept: in_ready never rose", i); end
      wait_done(cyc);
      checks++; if (cyc != 8) begin errors++; $display("FAIL rnd%0d_latency: got %0d want 8", i, cyc); end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      checks++; if ({ovf, bout, D} !== exp_r || out_valid !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_result: A=%h B=%h bin=%b got v=%b ovf=%b bout=%b D=%h want ovf=%b bout=%b D=%h",
                           i, a, b, bi, out_valid, ovf, bout, D, exp_r[33], exp_r[32], exp_r[31:0]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] na, nb;
    logic [33:0] exp1, exp2;
    bit ok;
    int cyc;
    exp1 = model(32'h12345678, 32'h0000ABCD, 1'b1);
    send(32'h12345678, 32'h0000ABCD, 1'b1, ok);
    wait_done(cyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL bp_latency1: got %0d want 8", cyc); end
    na = $urandom; nb = $urandom;
    exp2 = model(na, nb, 1'b0);
    A = na; B = nb; bin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if ({ovf, bout, D} !== exp1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d: got in_ready=%b out_valid=%b ovf=%b bout=%b D=%h want 0 1 %b %b %h",
                           i, in_ready, out_valid, ovf, bout, D, exp1[33], exp1[32], exp1[31:0]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept: got in_ready=%b want 0", in_ready); end
    wait_done(cyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL bp_latency2: got %0d want 8", cyc); end
    checks++; if ({ovf, bout, D} !== exp2) begin
      errors++; $display("FAIL bp_result2: got ovf=%b bout=%b D=%h want %b %b %h",
                         ovf, bout, D, exp2[33], exp2[32], exp2[31:0]);
    end
    consume();
  endtask

  task automatic test_reset_mid_busy();
    logic [33:0] exp_r;
    bit ok;
    int cyc;
    send(32'hDEADBEEF, 32'h01234567, 1'b0, ok);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({in_ready, out_valid} !== 2'b10 || D !== 32'h0 || {bout, ovf} !== 2'b00) begin
      errors++; $display("FAIL midbusy_reset: got in_ready=%b out_valid=%b D=%h bout=%b ovf=%b want 1 0 0 0 0",
                         in_ready, out_valid, D, bout, ovf);
    end
    exp_r = model(32'h00000100, 32'h00000001, 1'b1);
    send(32'h00000100, 32'h00000001, 1'b1, ok);
    wait_done(cyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL midbusy_latency: got %0d want 8", cyc); end
    checks++; if ({ovf, bout, D} !== exp_r) begin
      errors++; $display("FAIL midbusy_result: got ovf=%b bout=%b D=%h want %b %b %h",
                         ovf, bout, D, exp_r[33], exp_r[32], exp_r[31:0]);
    end
    consume();
  endtask

  task automatic test_reset_priority();
    bit ok;
    int cyc;
    send(32'h00000000, 32'h00000001, 1'b0, ok);
    wait_done(cyc);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; A = 32'h55555555; B = 32'h11111111;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    checks++; if ({in_ready, out_valid} !== 2'b10 || D !== 32'h0 || {bout, ovf} !== 2'b00) begin
      errors++; $display("FAIL prio_reset: got in_ready=%b out_valid=%b D=%h bout=%b ovf=%b want 1 0 0 0 0",
                         in_ready, out_valid, D, bout, ovf);
    end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL prio_no_accept: got in_ready=%b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_busy();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_csel_subtractor.md
SEQ_CSEL_SUBTRACTOR -- requirements
Module: seq_csel_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; it SHALL be a multiple of 4 and at least 8.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port in_valid, input, 1 bit: a request is presented.
REQ-005 Port in_ready, output, 1 bit: the block can accept a request.
REQ-006 Port A, input, WIDTH bits: minuend.
REQ-007 Port B, input, WIDTH bits: subtrahend.
REQ-008 Port bin, input, 1 bit: borrow-in.
REQ-009 Port out_valid, output, 1 bit: a result is presented.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 Port D, output, WIDTH bits: the difference A - B - bin.
REQ-012 Port bout, output, 1 bit: unsigned borrow-out.
REQ-013 Port ovf, output, 1 bit: signed two's-complement overflow.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE to BUSY: in_valid and in_ready high on the same edge; on that edge the block SHALL capture A, B and bin, and clear the slice counter k to 0.
REQ-017 In BUSY, each cycle SHALL process one 4-bit slice k (LSB first) as A_k + ~B_k + carry, where the initial carry is ~bin.
REQ-018 Each slice SHALL be evaluated carry-select style: both carry=0 and carry=1 results are precomputed, then the registered running carry selects one.
REQ-019 Each slice's sum SHALL be written into the D register, and its carry-out registered as the next running carry.
REQ-020 BUSY to DONE: SHALL occur on the edge that processes slice WIDTH/4-1. A request accepted at edge T gives out_valid=1 after edge T+WIDTH/4 (8 cycles for WIDTH=32).
REQ-021 bout SHALL equal the inverse of the final carry.
REQ-022 ovf SHALL be 1 when A[MSB] != B[MSB] and the raw D[MSB] != A[MSB].
REQ-023 DONE: D, bout and ovf SHALL stay stable while out_ready is 0.
REQ-024 DONE to IDLE: SHALL occur on the edge where out_ready=1. in_ready rises in the following cycle; there is no same-cycle accept.
REQ-025 in_valid SHALL be ignored outside IDLE, and A, B and bin changes after capture SHALL not affect the result.
REQ-026 WIDTH-bit results SHALL wrap modulo 2^WIDTH; the borrow is reported only via bout.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, k=0, D=0, bout=0, ovf=0, out_valid=0 and in_ready=1 after that edge, in any state.
REQ-028 Reset asserted mid-BUSY SHALL discard the partial result with no output handshake.
REQ-029 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-030 The macro CSEL_SUB_SAT_EN, when defined, SHALL make D saturate when ovf=1: to 1 followed by zeros (most-negative) if A[MSB]=1, else to 0 followed by ones (most-positive).
REQ-031 Saturation SHALL be applied on the transition into DONE; latency is unchanged.
REQ-032 Without CSEL_SUB_SAT_EN, D SHALL be the wrapped result and ovf SHALL still be reported.

Structure
REQ-033 Package csel_sub_pkg SHALL hold the constant SLICE_W=4 and the FSM state typedef (IDLE, BUSY, DONE).
REQ-034 Sub-module csel_sub_slice SHALL be the combinational 4-bit carry-select slice: inputs a[3:0], b[3:0], cin; outputs s[3:0], cout. It SHALL be instantiated once and reused every BUSY cycle.

Verification
REQ-035 WIDTH=32, A=0x00000005, B=0x00000003, bin=0 -> out_valid exactly 8 cycles after accept; D=0x00000002, bout=0, ovf=0.
REQ-036 A=0x00000000, B=0x00000001, bin=0 -> D=0xFFFFFFFF, bout=1, ovf=0.
REQ-037 A=0x80000000, B=0x00000001, bin=0 -> bout=0, ovf=1; D=0x7FFFFFFF without CSEL_SUB_SAT_EN, D=0x80000000 with it.
REQ-038 A=0x00000010, B=0x0000000F, bin=1 -> D=0x00000000, bout=0, ovf=0.
REQ-039 Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> D is stable and in_ready=0 throughout; out_ready=1 -> in_ready=1 the next cycle and the new operands are accepted then.
REQ-040 Assert rst for one cycle at BUSY cycle 3 -> next cycle IDLE, in_ready=1, out_valid=0, D=0; a following request completes correctly in 8 cycles.
